sw_result_writer: RTL and testbench
===================================

# sw_result_writer

Downstream stage of the systolic convolution array: captures the result words the array produces while its `valid` flag is high, buffers them in a small FIFO, and drains them as addressed write requests to the result memory port under `wr_ready` backpressure. It tracks one image section per `start`, detects section end from the array's `filters_finished` flag, and pulses `section_done` once every captured word has been written.

## Interface
- `DATA_W`, 512 — result word width (CACHE_WIDTH; 16 lanes × 32 bit).
- `ADDR_W`, 16 — result memory word address width.
- `FIFO_DEPTH`, 8 — buffer depth in words (power of two, ≥ 2).

- `clk`  in  1 — single clock; all logic on the rising edge.
- `resetb`  in  1 — synchronous, active-low reset.
- `start`  in  1 — one-cycle pulse that begins a section; honoured only in IDLE.
- `base_addr`  in  ADDR_W — first write address of the section; sampled with `start`.
- `in_valid`  in  1 — array result valid (array `valid`).
- `in_data`  in  DATA_W — array result word (array `result`).
- `in_finished`  in  1 — array `filters_finished` level.
- `wr_valid`  out  1 — write request valid.
- `wr_addr`  out  ADDR_W — write address.
- `wr_data`  out  DATA_W — write data.
- `wr_ready`  in  1 — memory accepts the request this cycle.
- `busy`  out  1 — high in any state other than IDLE.
- `section_done`  out  1 — one-cycle pulse when a section has been fully written.
- `overflow`  out  1 — sticky: a word was dropped because the FIFO was full.
- `words_written`  out  16 — words accepted by memory this section; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE: `start` → COLLECT; latch `base_addr` as the write pointer; clear `words_written`, `overflow`, and the FIFO.
- COLLECT: `in_valid` pushes `in_data`. Section end is a falling edge of `in_finished` (registered previous value 1, current 0) → DRAIN. A word with `in_valid` in the same cycle as the falling edge is still pushed.
- DRAIN: no pushes; `in_valid` is ignored. FIFO empty → DONE.
- DONE: `section_done`=1 for exactly one cycle → IDLE.
- `in_valid` in IDLE, DRAIN, or DONE is dropped silently and does not set `overflow`.
- `start` outside IDLE is ignored.
- The upstream array has no backpressure. A push with FIFO full and no pop in the same cycle drops the incoming word and sets `overflow`. Push and pop together while full is legal and loses nothing.
- Write side: `wr_valid` = FIFO non-empty; `wr_data` = FIFO head.
- `wr_addr` = latched base + number of words popped so far, modulo 2^ADDR_W; wrap at 0xFFFF→0x0000 is silent.
- Pop occurs on `wr_valid && wr_ready`. A pop increments the address offset and `words_written`.
- While `wr_valid`=1 and `wr_ready`=0, `wr_addr` and `wr_data` hold stable.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `section_done`=0, `overflow`=0, `words_written`=0, FSM=IDLE, FIFO empty.
- Reset mid-section aborts at once: FIFO flushed, no `section_done`.
- `start` at edge N → `busy`=1 after edge N. First capture can occur at edge N+1.
- Capture latency: word sampled at edge N → `wr_valid`=1 with that word after edge N. With `wr_ready` held high, one word is written per cycle.
- Falling edge of `in_finished` observed at edge N, FIFO holding k words, `wr_ready` held high: last pop at edge N+k; `section_done` high for the cycle after edge N+k+1; IDLE after edge N+k+2.
- Falling edge with the FIFO already empty: DRAIN lasts one cycle, then DONE.
- `overflow` and `words_written` hold their values through IDLE until the next `start`.

## Configuration
- `SW_RESULT_RELU_EN`
- Defined: each 32-bit lane of `in_data` with bit 31 set is replaced by 0 before the push (ReLU). The lane mapping is the array's PE lane mapping. Purely combinational; adds no latency.
- Undefined: words are stored unmodified.

## Test plan
- Basic section: `start` with `base_addr`=0x0100; 4 valid words; `in_finished` 1→0; `wr_ready`=1 → writes to 0x0100–0x0103 in order, `words_written`=4, one `section_done` pulse, `overflow`=0.
- Backpressure: 8 words pushed back-to-back with `wr_ready`=0, then `wr_ready` released → all 8 written in order, no drops; `wr_addr`/`wr_data` stable while stalled.
- Overflow: 10 words pushed with `wr_ready`=0 (FIFO_DEPTH=8) → words 9 and 10 dropped, `overflow`=1; only 8 writes after release; `overflow` cleared by the next `start`.
- Address wrap: `base_addr`=0xFFFE, 4 words → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-DRAIN: `resetb`=0 with 3 words buffered → next cycle all outputs at reset values, no `section_done`; a following section runs normally.
- ReLU (macro defined): lane 0 = 0xFFFF_FFF0, lane 1 = 0x0000_0005 → written lane 0 = 0, lane 1 = 5. Without the macro → written unchanged.

Source files
------------

// File: rtl/sw_result_writer.sv
// Result writer for the systolic convolution array: buffers array results in a small FIFO and
// drains them as addressed memory writes. Optional ReLU on capture via SW_RESULT_RELU_EN.
module sw_result_writer #(
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_finished,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              section_done,
    output logic              overflow,
    output logic [15:0]       words_written
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              fin_q;
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       words_q;
    logic              overflow_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              empty, full, pop, push_req, push, drop, start_ok;
    logic [DATA_W-1:0] push_data;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop      = !empty && wr_ready;
    assign push_req = (state_q == StCollect) && in_valid;
    // A simultaneous pop frees a slot, so a full FIFO can still accept the word.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign start_ok = (state_q == StIdle) && start;

    always_comb begin
        push_data = in_data;
`ifdef SW_RESULT_RELU_EN
        for (int i = 0; i < int'(DATA_W / 32); i++) begin
            if (in_data[32*i+31]) push_data[32*i +: 32] = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCollect;
            StCollect: if (fin_q && !in_finished) state_d = StDrain;
            StDrain:   if (empty) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q    <= StIdle;
            fin_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fin_q   <= in_finished;
            if (start_ok) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                addr_q     <= base_addr;
                words_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
                    addr_q   <= addr_q + ADDR_W'(1);
                    if (words_q != 16'hFFFF) words_q <= words_q + 16'd1;
                end
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; wr_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

    assign wr_valid      = !empty;
    assign wr_addr       = addr_q;
    assign wr_data       = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign busy          = (state_q != StIdle);
    assign section_done  = (state_q == StDone);
    assign overflow      = overflow_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_sw_result_writer.sv
// Directed bench for sw_result_writer: table of whole sections plus reset and ReLU sequences.
module tb_sw_result_writer;

    logic         clk;
    logic         resetb;
    logic         start;
    logic [15:0]  base_addr;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_finished;
    logic         wr_valid;
    logic [15:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready;
    logic         busy;
    logic         section_done;
    logic         overflow;
    logic [15:0]  words_written;

    sw_result_writer dut (
        .clk          (clk),
        .resetb       (resetb),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_finished  (in_finished),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .busy         (busy),
        .section_done (section_done),
        .overflow     (overflow),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] base;
        int          n;
        bit          stall;
        int          exp_writes;
        int          exp_k;     // words buffered when the falling edge is seen
        bit          exp_ovf;
        logic [15:0] exp_ww;
    } vec_t;

    vec_t         tbl [5];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    logic [15:0]  exp_addr [$];
    logic [511:0] exp_data [$];

    function automatic logic [511:0] mkword(input int id, input int k);
        logic [511:0] w;
        for (int j = 0; j < 16; j++) w[32*j +: 32] = {1'b0, 7'(j), 8'(id), 16'(k)};
        return w;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scores any write accepted at the coming edge, then advances one cycle.
    task automatic tick();
        if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
            chk("write_expected", 512'(exp_addr.size() > 0), 512'(1));
            if (exp_addr.size() > 0) begin
                chk("wr_addr", 512'(wr_addr), 512'(exp_addr.pop_front()));
                chk("wr_data", wr_data, exp_data.pop_front());
            end
        end
        if (section_done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_valid"}, 512'(wr_valid), 512'(0));
        chk({tag, "_wr_addr"}, 512'(wr_addr), 512'(0));
        chk({tag, "_wr_data"}, wr_data, 512'(0));
        chk({tag, "_busy"}, 512'(busy), 512'(0));
        chk({tag, "_section_done"}, 512'(section_done), 512'(0));
        chk({tag, "_overflow"}, 512'(overflow), 512'(0));
        chk({tag, "_words_written"}, 512'(words_written), 512'(0));
    endtask

    task automatic drain(input int exp_k, input bit exp_ovf, input logic [15:0] exp_ww);
        int i;
        int done_at;
        i        = 0;
        done_at  = -1;
        done_cnt = 0;
        wr_ready = 1'b1;
        in_valid = 1'b0;
        while (busy === 1'b1 && i < 40) begin
            if (section_done === 1'b1 && done_at < 0) done_at = i;
            tick();
            i++;
        end
        chk("drain_finished", 512'(busy), 512'(0));
        chk("done_cycle", 512'(done_at), 512'(exp_k + 1));
        chk("done_pulses", 512'(done_cnt), 512'(1));
        chk("idle_cycle", 512'(i), 512'(exp_k + 2));
        chk("writes_left", 512'(exp_addr.size()), 512'(0));
        chk("overflow", 512'(overflow), 512'(exp_ovf));
        chk("words_written", 512'(words_written), 512'(exp_ww));
        chk("wr_valid_idle", 512'(wr_valid), 512'(0));
    endtask

    task automatic run_section(input vec_t v);
        logic [15:0] a;
        start       = 1'b1;
        base_addr   = v.base;
        in_finished = 1'b1;
        in_valid    = 1'b0;
        wr_ready    = !v.stall;
        tick();
        start = 1'b0;
        chk("start_busy", 512'(busy), 512'(1));
        chk("start_overflow_clr", 512'(overflow), 512'(0));
        chk("start_words_clr", 512'(words_written), 512'(0));
        for (int k = 0; k < v.n; k++) begin
            in_valid = 1'b1;
            in_data  = mkword(v.id, k);
            if (k == v.n - 1) in_finished = 1'b0;
            if (k < v.exp_writes) begin
                a = v.base + 16'(k);
                exp_addr.push_back(a);
                exp_data.push_back(mkword(v.id, k));
            end
            if (v.stall && k > 0) begin
                chk("stall_valid", 512'(wr_valid), 512'(1));
                chk("stall_addr", 512'(wr_addr), 512'(v.base));
                chk("stall_data", wr_data, mkword(v.id, 0));
            end
            tick();
        end
        if (v.n == 0) begin
            in_finished = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        drain(v.exp_k, v.exp_ovf, v.exp_ww);
    endtask

    initial begin
        logic [511:0] d;
        logic [511:0] e;
        tbl[0] = '{id: 0, base: 16'h0100, n: 4,  stall: 0, exp_writes: 4, exp_k: 1,
                   exp_ovf: 0, exp_ww: 16'd4};
        tbl[1] = '{id: 1, base: 16'h0200, n: 8,  stall: 1, exp_writes: 8, exp_k: 8,
                   exp_ovf: 0, exp_ww: 16'd8};
        tbl[2] = '{id: 2, base: 16'h0300, n: 10, stall: 1, exp_writes: 8, exp_k: 8,
                   exp_ovf: 1, exp_ww: 16'd8};
        tbl[3] = '{id: 3, base: 16'hFFFE, n: 4,  stall: 0, exp_writes: 4, exp_k: 1,
                   exp_ovf: 0, exp_ww: 16'd4};
        tbl[4] = '{id: 4, base: 16'h0400, n: 0,  stall: 0, exp_writes: 0, exp_k: 0,
                   exp_ovf: 0, exp_ww: 16'd0};

        resetb      = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_finished = 1'b0;
        wr_ready    = 1'b0;
        tick();
        tick();
        chk_reset_vals("por");
        resetb = 1'b1;
        tick();

        for (int t = 0; t < 5; t++) run_section(tbl[t]);

        // Reset while draining three stalled words: no write, no done pulse.
        start       = 1'b1;
        base_addr   = 16'h0500;
        in_finished = 1'b1;
        wr_ready    = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = mkword(5, k);
            if (k == 2) in_finished = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("drain_busy", 512'(busy), 512'(1));
        resetb = 1'b0;
        tick();
        chk_reset_vals("mid_reset");
        resetb   = 1'b1;
        wr_ready = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("reset_no_done", 512'(done_cnt), 512'(0));
        chk("reset_no_valid", 512'(wr_valid), 512'(0));
        run_section(tbl[0]);

        // ReLU lanes: negative lane 0 cleared only when the feature is built in.
        d           = '0;
        d[31:0]     = 32'hFFFF_FFF0;
        d[63:32]    = 32'h0000_0005;
        e           = d;
`ifdef SW_RESULT_RELU_EN
        e[31:0]     = 32'h0;
`endif
        start       = 1'b1;
        base_addr   = 16'h0800;
        in_finished = 1'b1;
        wr_ready    = 1'b1;
        tick();
        start       = 1'b0;
        in_valid    = 1'b1;
        in_data     = d;
        in_finished = 1'b0;
        exp_addr.push_back(16'h0800);
        exp_data.push_back(e);
        tick();
        in_valid = 1'b0;
        drain(1, 1'b0, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
